serializador_resultado: RTL
===========================

Name: serializador_resultado

Overview:
- Upstream stage of the 8-bit output block-select register.
- Captures one 32-bit ALU result through a valid/ready handshake.
- Emits the result as four 8-bit blocks, most-significant first, one per accepted beat.
- Drives the 2-bit block selector alongside each byte: 00 = bits 31:24, 01 = 23:16, 10 = 15:8, 11 = 7:0.

Parameters:
- DATA_W, 32, width of captured result; must be a multiple of BLK_W.
- BLK_W, 8, width of each emitted block.
- NUM_BLK, DATA_W/BLK_W (4), derived localparam; number of beats per word.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  block can accept a result.
- in_data  input  DATA_W  ALU result word.
- out_valid  output  1  out_byte/out_sel valid.
- out_ready  input  1  downstream accepts current block.
- out_byte  output  BLK_W  current block.
- out_sel  output  $clog2(NUM_BLK)  block index of out_byte.
- out_last  output  1  high with the final block (index NUM_BLK-1).
- busy  output  1  high while a word is held.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at a rising edge), regardless of state:
  - state=IDLE, in_ready=1, out_valid=0, out_sel=0, out_byte=0, out_last=0, busy=0.
  - Held word cleared to 0.
- FSM states: IDLE and SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 at an edge: capture in_data, set out_sel=0, go to SEND.
- SEND:
  - in_ready=0, out_valid=1, busy=1.
  - out_byte = held word bits [DATA_W-1-out_sel*BLK_W -: BLK_W].
  - out_last = (out_sel==NUM_BLK-1).
  - Beat completes on an edge with out_valid&&out_ready: out_sel increments.
  - If out_last=1 when the beat completes, go to IDLE instead.
- Latency: word accepted at edge N → first block valid after edge N (cycle N+1). Four beats minimum with out_ready=1. Next word can be accepted no earlier than the cycle after the last beat (one bubble). Throughput is 1 word per 5 cycles.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_byte, out_sel and out_last hold stable.
  - No beat is ever skipped or repeated.
- in_valid in SEND is ignored (in_ready=0); upstream must hold its data.
- out_sel wraps only via the SEND→IDLE transition; it never counts past NUM_BLK-1.
- All outputs are registered or decoded from registered state; there is no combinational path from in_* to out_*.
- Reset asserted mid-word: the word is discarded and no further beats are emitted. The first cycle after reset deasserts shows IDLE values.

Optional Feature:
- Macro SERIAL_PARITY_EN.
- Defined:
  - Adds output out_parity (1 bit) = even parity (XOR reduction) of out_byte.
  - Valid whenever out_valid=1; held stable under backpressure.
  - Reset value 0.
- Undefined: port absent, no parity logic; all other behaviour identical.

Decomposition:
- Package serializador_pkg holds:
  - state enum (IDLE, SEND).
  - Default constants DATA_W_DEF=32, BLK_W_DEF=8.
  - typedef blk_idx_t (logic [1:0]) for the block selector, so the downstream block-select register uses the same encoding.
- No sub-module; the block slice is a single indexed part-select inside this module.

Test Plan:
- Accept 0xA1B2C3D4 with out_ready=1 → out_byte A1,B2,C3,D4 on four consecutive cycles, out_sel 0,1,2,3, out_last only on D4; in_ready returns to 1 the next cycle.
- Same word, out_ready low for 3 cycles during block 01 → out_byte=B2 and out_sel=1 held for 3 cycles; sequence completes with no loss or duplication.
- in_valid held high with 0x11223344 then 0x55667788 → first word fully emitted, one bubble cycle, then 55,66,77,88; second word not captured while busy.
- rst_n=0 for one edge during block 10 of 0xDEADBEEF → next cycle out_valid=0, busy=0, out_sel=0, in_ready=1; no further bytes emitted.
- in_data=0xFFFFFFFF, out_ready=1 → four beats of 0xFF; with SERIAL_PARITY_EN, out_parity=0 each beat. With 0x01800307, out_parity=1,1,0,1.
- Reset held while in_valid=1 → nothing captured; first capture occurs on the first edge after rst_n=1.

Source files
------------

// File: rtl/serializador_resultado_pkg.sv
// Package serializador_pkg: shared types and defaults for serializador_resultado.
//   state_e     - serializer FSM states (IDLE, SEND)
//   DATA_W_DEF  - default captured result width (32)
//   BLK_W_DEF   - default emitted block width (8)
//   blk_idx_t   - block selector encoding, shared with the downstream
//                 block-select register (00 = bits 31:24 ... 11 = bits 7:0)
package serializador_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int BLK_W_DEF  = 8;

  typedef logic [1:0] blk_idx_t;

endpackage

// File: rtl/serializador_resultado_if.sv
// Interface serializador_resultado_if: result-in / block-out handshake bundle.
//   in_valid, in_data, in_ready      - upstream ALU result (valid/ready)
//   out_valid, out_ready             - downstream block handshake
//   out_byte, out_sel, out_last      - current block, its index, final-block flag
//   busy                             - a word is being held
//   out_parity                       - even parity of out_byte (only when
//                                      SERIAL_PARITY_EN is defined)
// Modports: master = upstream/downstream environment, slave = serializer.
interface serializador_resultado_if
  import serializador_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BLK_W  = BLK_W_DEF
);

  localparam int NUM_BLK = DATA_W / BLK_W;
  localparam int SEL_W   = $clog2(NUM_BLK);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [BLK_W-1:0]  out_byte;
  logic [SEL_W-1:0]  out_sel;
  logic              out_last;
  logic              busy;
`ifdef SERIAL_PARITY_EN
  logic              out_parity;
`endif

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_byte,
    input  out_sel,
    input  out_last,
`ifdef SERIAL_PARITY_EN
    input  out_parity,
`endif
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_byte,
    output out_sel,
    output out_last,
`ifdef SERIAL_PARITY_EN
    output out_parity,
`endif
    output busy
  );

endinterface

// File: rtl/serializador_resultado.sv
// serializador_resultado: captures one DATA_W-bit ALU result and emits it as
// NUM_BLK blocks of BLK_W bits, most-significant block first, one block per
// accepted out_valid/out_ready beat.
// Ports:
//   clk    - single rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - serializador_resultado_if.slave (in_* handshake, out_* blocks, busy)
// Optional build macro: SERIAL_PARITY_EN adds bus.out_parity (even parity of
// out_byte, 0 whenever out_valid is low).
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no word held; in_ready=1, waiting for in_valid
// SEND  | word held; presenting block out_sel until the last beat
module serializador_resultado
  import serializador_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BLK_W  = BLK_W_DEF
)(
  input  logic                      clk,
  input  logic                      rst_n,
  serializador_resultado_if.slave   bus
);

  localparam int NUM_BLK = DATA_W / BLK_W;
  localparam int SEL_W   = $clog2(NUM_BLK);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_BLK - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] word_shl;
  logic              sending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = SEND;
          word_d  = bus.in_data;
          sel_d   = '0;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          // selector returns to 0 only through the SEND->IDLE transition
          if (sel_q == LAST_SEL) begin
            state_d = IDLE;
            sel_d   = '0;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sending = (state_q == SEND);

  // Left-shifting by sel*BLK_W brings the selected block to the top, so
  // block 0 is the most-significant slice of the held word.
  assign word_shl = word_q << (32'(sel_q) * BLK_W);

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = sending;
  assign bus.busy      = sending;
  assign bus.out_sel   = sel_q;
  assign bus.out_last  = sending && (sel_q == LAST_SEL);
  assign bus.out_byte  = sending ? word_shl[DATA_W-1 -: BLK_W] : '0;

`ifdef SERIAL_PARITY_EN
  assign bus.out_parity = ^bus.out_byte;
`endif

endmodule
